// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline sequencer, its bus arbiter and the instruction decoder.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_IF  = 2'd1,
        OWN_MEM = 2'd2
    } arb_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bit positions of the two requesters inside the arbiter req/grant vectors
    localparam int REQ_IF  = 0;
    localparam int REQ_MEM = 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Shared-bus handshake between the pipeline sequencer (master) and the IF/MEM stages plus bus (slave).
interface pipeline_hazard_ctrl_if;

    logic if_req;
    logic mem_req;
    logic bus_ack;
    logic bus_grant_if;
    logic bus_grant_mem;
    logic fetch_discard;

    modport master (
        input  if_req,
        input  mem_req,
        input  bus_ack,
        output bus_grant_if,
        output bus_grant_mem,
        output fetch_discard
    );

    modport slave (
        output if_req,
        output mem_req,
        output bus_ack,
        input  bus_grant_if,
        input  bus_grant_mem,
        input  fetch_discard
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_bus_arbiter2.sv
// Two-requester bus arbiter: fixed priority from idle, round-robin on completion so grants chain without gaps.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | bus free, nobody granted
//   OWN_IF  | fetch transaction in flight, waiting for ack
//   OWN_MEM | load/store transaction in flight, waiting for ack
module bus_arbiter2
    import pipeline_pkg::*;
#(
    parameter bit MEM_PRIO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       ack,
    output logic [1:0] grant
);

    arb_state_t state;
    arb_state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req[REQ_MEM] && (MEM_PRIO || !req[REQ_IF])) begin
                    state_next = OWN_MEM;
                end else if (req[REQ_IF]) begin
                    state_next = OWN_IF;
                end
            end
            // On completion the other requester is served first
            OWN_IF: begin
                if (ack) begin
                    if (req[REQ_MEM]) begin
                        state_next = OWN_MEM;
                    end else if (req[REQ_IF]) begin
                        state_next = OWN_IF;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            OWN_MEM: begin
                if (ack) begin
                    if (req[REQ_IF]) begin
                        state_next = OWN_IF;
                    end else if (req[REQ_MEM]) begin
                        state_next = OWN_MEM;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            grant[REQ_IF]  = (state == OWN_IF);
            grant[REQ_MEM] = (state == OWN_MEM);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: bus sharing between IF and MEM, load-use detection, stall/bubble
// control of the PC and pipeline registers, and squashing of fetches made stale by a taken branch.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit MEM_PRIO   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  branch_taken,
    pipeline_hazard_ctrl_if.master bus,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  stall_idex,
    output logic                  stall_exmem,
    output logic                  bubble_ifid,
    output logic                  bubble_idex,
    output logic                  bubble_memwb
);

    logic [1:0] grant;
    logic       ack_if;
    logic       ack_mem;
    logic       mem_wait;
    logic       if_wait;
    logic       load_use;
    logic       branch_eff;
    logic       discard;
    logic       drop_pending;

    bus_arbiter2 #(
        .MEM_PRIO (MEM_PRIO)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.mem_req, bus.if_req}),
        .ack   (bus.bus_ack),
        .grant (grant)
    );

    assign bus.bus_grant_if  = grant[REQ_IF];
    assign bus.bus_grant_mem = grant[REQ_MEM];

    assign ack_if   = grant[REQ_IF]  && bus.bus_ack;
    assign ack_mem  = grant[REQ_MEM] && bus.bus_ack;
    assign mem_wait = bus.mem_req && !ack_mem;
    assign if_wait  = bus.if_req  && !ack_if;
    assign load_use = ex_is_load && (ex_rd != REG_ADDR_W'(REG_ZERO))
                      && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

    // While MEM is stalled EX is frozen, so its branch outcome is re-presented on release
    assign branch_eff = branch_taken && !mem_wait;
    assign discard    = !reset && ack_if && (drop_pending || branch_eff);
    assign bus.fetch_discard = discard;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_pending <= 1'b0;
        end else if (discard) begin
            drop_pending <= 1'b0;
        end else if (branch_eff && grant[REQ_IF] && !bus.bus_ack) begin
            drop_pending <= 1'b1;
        end
    end

    always_comb begin
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idex   = 1'b0;
        stall_exmem  = 1'b0;
        bubble_ifid  = 1'b0;
        bubble_idex  = 1'b0;
        bubble_memwb = 1'b0;
        if (!reset) begin
            if (mem_wait) begin
                stall_pc     = 1'b1;
                stall_ifid   = 1'b1;
                stall_idex   = 1'b1;
                stall_exmem  = 1'b1;
                bubble_memwb = 1'b1;
            end else if (branch_eff) begin
                bubble_ifid = 1'b1;
                bubble_idex = 1'b1;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end else if (if_wait) begin
                stall_pc    = 1'b1;
                bubble_ifid = 1'b1;
            end
            // A held IF/ID already keeps the stale fetch out; only bubble when it would load
            if (discard && !stall_ifid) begin
                bubble_ifid = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with hand-computed expected control patterns.
module tb_pipeline_hazard_ctrl;

    // ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_ifid, bubble_idex, bubble_memwb}
    localparam logic [6:0] C_NONE     = 7'b0000_000;
    localparam logic [6:0] C_MEMSTALL = 7'b1111_001;
    localparam logic [6:0] C_BRANCH   = 7'b0000_110;
    localparam logic [6:0] C_LOADUSE  = 7'b1100_010;
    localparam logic [6:0] C_IFWAIT   = 7'b1000_100;
    localparam logic [6:0] C_DROPONLY = 7'b0000_100;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       branch_taken;
    logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic       bubble_ifid, bubble_idex, bubble_memwb;
    logic [6:0] ctl;
    logic [1:0] gnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl_if bus_if ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .MEM_PRIO   (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .branch_taken (branch_taken),
        .bus          (bus_if.master),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .stall_idex   (stall_idex),
        .stall_exmem  (stall_exmem),
        .bubble_ifid  (bubble_ifid),
        .bubble_idex  (bubble_idex),
        .bubble_memwb (bubble_memwb)
    );

    assign ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_ifid, bubble_idex, bubble_memwb};
    assign gnt = {bus_if.bus_grant_mem, bus_if.bus_grant_if};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1         = 5'd0;
        id_rs2         = 5'd0;
        ex_rd          = 5'd0;
        ex_is_load     = 1'b0;
        branch_taken   = 1'b0;
        bus_if.if_req  = 1'b0;
        bus_if.mem_req = 1'b0;
        bus_if.bus_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.if_req  = 1'b1;
        bus_if.mem_req = 1'b1;
        bus_if.bus_ack = 1'b1;
        branch_taken   = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
        tick();
        tick();
        n_tests++;
        if (ctl !== C_NONE || gnt !== 2'b00 || bus_if.fetch_discard !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs ctl=%b gnt=%b disc=%b exp ctl=%b gnt=00 disc=0", ctl, gnt, bus_if.fetch_discard, C_NONE);
        end
        clear_inputs();
        reset = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 2'b00 || ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL reset_idle gnt=%b ctl=%b exp gnt=00 ctl=%b", gnt, ctl, C_NONE);
        end
    endtask

    task automatic test_if_fetch();
        do_reset();
        bus_if.if_req = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b00 || ctl !== C_IFWAIT) begin
            n_fail++;
            $display("FAIL if_req_c0 gnt=%b ctl=%b exp gnt=00 ctl=%b", gnt, ctl, C_IFWAIT);
        end
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_tests++;
            if (gnt !== 2'b01 || ctl !== C_IFWAIT) begin
                n_fail++;
                $display("FAIL if_wait_c%0d gnt=%b ctl=%b exp gnt=01 ctl=%b", c, gnt, ctl, C_IFWAIT);
            end
        end
        tick();
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_NONE || bus_if.fetch_discard !== 1'b0) begin
            n_fail++;
            $display("FAIL if_ack ctl=%b disc=%b exp ctl=%b disc=0", ctl, bus_if.fetch_discard, C_NONE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_prio();
        do_reset();
        bus_if.if_req  = 1'b1;
        bus_if.mem_req = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b00 || ctl !== C_MEMSTALL) begin
            n_fail++;
            $display("FAIL prio_c0 gnt=%b ctl=%b exp gnt=00 ctl=%b", gnt, ctl, C_MEMSTALL);
        end
        tick();
        n_tests++;
        if (gnt !== 2'b10 || ctl !== C_MEMSTALL) begin
            n_fail++;
            $display("FAIL prio_grant gnt=%b ctl=%b exp gnt=10 ctl=%b", gnt, ctl, C_MEMSTALL);
        end
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_IFWAIT) begin
            n_fail++;
            $display("FAIL prio_mem_ack ctl=%b exp %b", ctl, C_IFWAIT);
        end
        tick();
        bus_if.mem_req = 1'b0;
        bus_if.bus_ack = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 2'b01 || ctl !== C_IFWAIT) begin
            n_fail++;
            $display("FAIL prio_handover gnt=%b ctl=%b exp gnt=01 ctl=%b", gnt, ctl, C_IFWAIT);
        end
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL prio_if_ack ctl=%b exp %b", ctl, C_NONE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_if.if_req = 1'b1;
        tick();
        bus_if.mem_req = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b01 || ctl !== C_MEMSTALL) begin
            n_fail++;
            $display("FAIL b2b_if_own gnt=%b ctl=%b exp gnt=01 ctl=%b", gnt, ctl, C_MEMSTALL);
        end
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_MEMSTALL || bus_if.fetch_discard !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_if_ack ctl=%b disc=%b exp ctl=%b disc=0", ctl, bus_if.fetch_discard, C_MEMSTALL);
        end
        tick();
        bus_if.bus_ack = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_rr_mem gnt=%b exp 10", gnt);
        end
        bus_if.bus_ack = 1'b1;
        #1;
        tick();
        bus_if.mem_req = 1'b0;
        bus_if.bus_ack = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_rr_if gnt=%b exp 01", gnt);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
        #1;
        n_tests++;
        if (ctl !== C_LOADUSE) begin
            n_fail++;
            $display("FAIL lu_rs2 ctl=%b exp %b", ctl, C_LOADUSE);
        end
        tick();
        ex_is_load = 1'b0;
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL lu_release ctl=%b exp %b", ctl, C_NONE);
        end
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL lu_x0 ctl=%b exp %b", ctl, C_NONE);
        end
        ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd2;
        #1;
        n_tests++;
        if (ctl !== C_LOADUSE) begin
            n_fail++;
            $display("FAIL lu_rs1 ctl=%b exp %b", ctl, C_LOADUSE);
        end
        ex_is_load = 1'b0;
        #1;
        n_tests++;
        if (ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL lu_not_load ctl=%b exp %b", ctl, C_NONE);
        end
        clear_inputs();
    endtask

    task automatic test_branch_discard();
        do_reset();
        bus_if.if_req = 1'b1;
        tick();
        branch_taken = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_BRANCH || bus_if.fetch_discard !== 1'b0) begin
            n_fail++;
            $display("FAIL br_flush ctl=%b disc=%b exp ctl=%b disc=0", ctl, bus_if.fetch_discard, C_BRANCH);
        end
        for (int c = 1; c <= 2; c++) begin
            tick();
            branch_taken = 1'b0;
            #1;
            n_tests++;
            if (ctl !== C_IFWAIT || bus_if.fetch_discard !== 1'b0) begin
                n_fail++;
                $display("FAIL br_wait_c%0d ctl=%b disc=%b exp ctl=%b disc=0", c, ctl, bus_if.fetch_discard, C_IFWAIT);
            end
        end
        tick();
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (bus_if.fetch_discard !== 1'b1 || ctl !== C_DROPONLY) begin
            n_fail++;
            $display("FAIL br_discard disc=%b ctl=%b exp disc=1 ctl=%b", bus_if.fetch_discard, ctl, C_DROPONLY);
        end
        tick();
        bus_if.bus_ack = 1'b0;
        tick();
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (bus_if.fetch_discard !== 1'b0 || ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL br_pending_clr disc=%b ctl=%b exp disc=0 ctl=%b", bus_if.fetch_discard, ctl, C_NONE);
        end
        tick();
        branch_taken   = 1'b1;
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (bus_if.fetch_discard !== 1'b1 || ctl !== C_BRANCH) begin
            n_fail++;
            $display("FAIL br_same_cycle disc=%b ctl=%b exp disc=1 ctl=%b", bus_if.fetch_discard, ctl, C_BRANCH);
        end
        tick();
        branch_taken = 1'b0;
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (bus_if.fetch_discard !== 1'b0) begin
            n_fail++;
            $display("FAIL br_same_no_pend disc=%b exp 0", bus_if.fetch_discard);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_priority_over_all();
        do_reset();
        bus_if.mem_req = 1'b1;
        tick();
        branch_taken = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
        #1;
        n_tests++;
        if (ctl !== C_MEMSTALL || bus_if.fetch_discard !== 1'b0) begin
            n_fail++;
            $display("FAIL mw_dominant ctl=%b disc=%b exp ctl=%b disc=0", ctl, bus_if.fetch_discard, C_MEMSTALL);
        end
        tick();
        n_tests++;
        if (ctl !== C_MEMSTALL) begin
            n_fail++;
            $display("FAIL mw_hold ctl=%b exp %b", ctl, C_MEMSTALL);
        end
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_BRANCH) begin
            n_fail++;
            $display("FAIL mw_release ctl=%b exp %b", ctl, C_BRANCH);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_txn();
        do_reset();
        bus_if.mem_req = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL rmt_grant gnt=%b exp 10", gnt);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b00 || ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL rmt_during gnt=%b ctl=%b exp gnt=00 ctl=%b", gnt, ctl, C_NONE);
        end
        tick();
        reset = 1'b0;
        bus_if.mem_req = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 2'b00 || ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL rmt_after gnt=%b ctl=%b exp gnt=00 ctl=%b", gnt, ctl, C_NONE);
        end
        bus_if.bus_ack = 1'b1;
        #1;
        n_tests++;
        if (ctl !== C_NONE || bus_if.fetch_discard !== 1'b0) begin
            n_fail++;
            $display("FAIL rmt_stray_ack ctl=%b disc=%b exp ctl=%b disc=0", ctl, bus_if.fetch_discard, C_NONE);
        end
        tick();
        bus_if.bus_ack = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL rmt_idle gnt=%b exp 00", gnt);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_if_fetch();
        test_mem_prio();
        test_back_to_back();
        test_load_use();
        test_branch_discard();
        test_mem_priority_over_all();
        test_reset_mid_txn();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
